// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter with independent read/write channels.
// Define DBUS_ARB_RR_EN for round-robin; default is fixed priority with starvation guard.
module dbus_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_rd,
   input  logic [31:0] m0_raddr,
   output logic [31:0] m0_rdata,
   output logic        m0_rvalid,
   input  logic        m0_wr,
   input  logic [31:0] m0_waddr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_rgnt,
   output logic        m0_wgnt,
   output logic        m0_stall,
   input  logic        m1_rd,
   input  logic [31:0] m1_raddr,
   output logic [31:0] m1_rdata,
   output logic        m1_rvalid,
   input  logic        m1_wr,
   input  logic [31:0] m1_waddr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_rgnt,
   output logic        m1_wgnt,
   output logic        m1_stall,
   output logic        s_rd,
   output logic [31:0] s_raddr,
   input  logic [31:0] s_rdata,
   output logic        s_wr,
   output logic [31:0] s_waddr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb
);

   logic r_conf, w_conf;
   logic r_win1, w_win1;
   logic rpend_q, rpend_d;
   logic rsel_q, rsel_d;

   assign r_conf = m0_rd & m1_rd;
   assign w_conf = m0_wr & m1_wr;

`ifdef DBUS_ARB_RR_EN
   // last-winner bit: 1 means master 1 won the previous conflict
   logic rlast_q, rlast_d;
   logic wlast_q, wlast_d;

   assign r_win1 = ~rlast_q;
   assign w_win1 = ~wlast_q;

   always_comb begin
      rlast_d = rlast_q;
      wlast_d = wlast_q;
      if (r_conf) rlast_d = r_win1;
      if (w_conf) wlast_d = w_win1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rlast_q <= 1'b1;
         wlast_q <= 1'b1;
      end else begin
         rlast_q <= rlast_d;
         wlast_q <= wlast_d;
      end
   end
`else
   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   logic [7:0] rwait_q, rwait_d;
   logic [7:0] wwait_q, wwait_d;

   assign r_win1 = (rwait_q == WAIT_MAX);
   assign w_win1 = (wwait_q == WAIT_MAX);

   always_comb begin
      rwait_d = '0;
      wwait_d = '0;
      if (m1_rd & ~m1_rgnt)
         rwait_d = r_win1 ? rwait_q : rwait_q + 8'd1;
      if (m1_wr & ~m1_wgnt)
         wwait_d = w_win1 ? wwait_q : wwait_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rwait_q <= '0;
         wwait_q <= '0;
      end else begin
         rwait_q <= rwait_d;
         wwait_q <= wwait_d;
      end
   end
`endif

   assign m0_rgnt = ~rst & m0_rd & ~(r_conf & r_win1);
   assign m1_rgnt = ~rst & m1_rd & (~m0_rd | r_win1);
   assign m0_wgnt = ~rst & m0_wr & ~(w_conf & w_win1);
   assign m1_wgnt = ~rst & m1_wr & (~m0_wr | w_win1);

   assign m0_stall = ~rst & ((m0_rd & ~m0_rgnt) | (m0_wr & ~m0_wgnt));
   assign m1_stall = ~rst & ((m1_rd & ~m1_rgnt) | (m1_wr & ~m1_wgnt));

   always_comb begin
      s_rd    = 1'b0;
      s_raddr = '0;
      s_wr    = 1'b0;
      s_waddr = '0;
      s_wdata = '0;
      s_wstrb = '0;
      if (m0_rgnt) begin
         s_rd    = 1'b1;
         s_raddr = m0_raddr;
      end else if (m1_rgnt) begin
         s_rd    = 1'b1;
         s_raddr = m1_raddr;
      end
      if (m0_wgnt) begin
         s_wr    = 1'b1;
         s_waddr = m0_waddr;
         s_wdata = m0_wdata;
         s_wstrb = m0_wstrb;
      end else if (m1_wgnt) begin
         s_wr    = 1'b1;
         s_waddr = m1_waddr;
         s_wdata = m1_wdata;
         s_wstrb = m1_wstrb;
      end
   end

   // one-deep return routing lets reads from either master issue every cycle
   assign rpend_d = m0_rgnt | m1_rgnt;
   assign rsel_d  = rpend_d ? m1_rgnt : rsel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rpend_q <= 1'b0;
         rsel_q  <= 1'b0;
      end else begin
         rpend_q <= rpend_d;
         rsel_q  <= rsel_d;
      end
   end

   assign m0_rvalid = ~rst & rpend_q & ~rsel_q;
   assign m1_rvalid = ~rst & rpend_q & rsel_q;
   assign m0_rdata  = m0_rvalid ? s_rdata : '0;
   assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the CPU data bus. Master 0 is the RISC-V core's data port; master 1 is a secondary bus master such as a UART boot loader or DMA. The block sits between those masters and the address-decoded read/write bus fabric. The read and write channels are arbitrated independently, read data is routed back to the master that issued the read, and a per-master stall tells a losing master to hold its request.

## Interface
Parameters:
- `MAX_WAIT`, default 4: maximum consecutive denied cycles for master 1 in fixed-priority mode. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mN_rd`  in  1  read request, master N (N = 0, 1)
- `mN_raddr`  in  32  read byte address
- `mN_rdata`  out  32  read data; valid when `mN_rvalid`=1, else 0
- `mN_rvalid`  out  1  read data returned this cycle (registered)
- `mN_wr`  in  1  write request
- `mN_waddr`  in  32  write byte address
- `mN_wdata`  in  32  write data
- `mN_wstrb`  in  4  byte strobes
- `mN_rgnt`  out  1  read request accepted this cycle (combinational)
- `mN_wgnt`  out  1  write request accepted this cycle (combinational)
- `mN_stall`  out  1  `(mN_rd & ~mN_rgnt) | (mN_wr & ~mN_wgnt)`
- `s_rd`, `s_raddr[31:0]`  out  1/32  downstream read request and address
- `s_rdata`  in  32  downstream read data; valid one cycle after `s_rd`
- `s_wr`, `s_waddr[31:0]`, `s_wdata[31:0]`, `s_wstrb[3:0]`  out  downstream write channel

## Operation
- Each channel (read, write) has its own single-cycle arbiter. Grant is decided combinationally from the current requests plus registered policy state.
- Single requester on a channel: granted the same cycle.
- Both masters request the same channel: one winner, chosen by the policy in Configuration. The loser's grant is 0 and its stall is 1. The loser must hold its request and payload unchanged until it is granted.
- Downstream signals are a mux of the winner's signals. With no grant, `s_rd`/`s_wr` = 0 and the address/data/strobe outputs = 0.
- Read return: registered `rsel_q` (winner id) and `rpend_q` are captured on each granted read. In the next cycle `mK_rvalid` = 1 for K = `rsel_q` and `mK_rdata` = `s_rdata`; the other master sees rvalid 0 and rdata 0.
- Back-to-back reads by different masters are allowed every cycle, because return routing is pipelined one deep.
- The read and write channels may be granted to different masters in the same cycle.
- A master requesting rd and wr in the same cycle can receive a partial grant. It stalls until both are granted; an already-granted channel is re-issued only if the master still asserts it, and the master drops it after its grant.

## Timing
- Reset (`rst`=1 at a rising edge): `rpend_q`=0, `rsel_q`=0, both wait counters=0, both last-winner bits=1 (master 0 wins the next conflict in RR mode).
- While `rst`=1: all grants, `s_rd`, `s_wr`, `mN_rvalid` and `mN_stall` are forced to 0, and all data/address outputs are 0.
- Reset mid-read: a read granted in cycle N with `rst`=1 in cycle N+1 produces no rvalid; the returning data is dropped.
- Grant latency is 0 cycles; read data latency is 1 cycle after grant.
- Fixed-priority wait counter (one per channel, width 8): increments each cycle master 1 requests and is denied, saturating at `MAX_WAIT`. It clears when master 1 is granted or drops its request.
- Boundary: if the counter equals `MAX_WAIT` during a conflict, master 1 wins that cycle and the counter clears at the next edge.

## Configuration
- `DBUS_ARB_RR_EN` undefined: fixed priority, master 0 wins conflicts except when the master 1 starvation counter has reached `MAX_WAIT`.
- `DBUS_ARB_RR_EN` defined: round-robin per channel.
  - On conflict, the master that did not win the previous conflict on that channel wins.
  - The last-winner bit updates only on conflict cycles.
  - The wait counters and `MAX_WAIT` are not built.

## Test plan
- Reset release, then single read by master 0 to 0x0100_0010 with `s_rdata`=0xDEADBEEF → `m0_rgnt`=1 and `s_rd`=1 in cycle 0; `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF in cycle 1; `m1_rvalid`=0.
- Both masters write continuously (fixed mode, `MAX_WAIT`=4) → master 0 granted 4 cycles, master 1 granted on the 5th, and the pattern repeats; `m1_stall`=1 exactly in its denied cycles.
- RR build, both masters read every cycle → grants alternate m0, m1, m0, …; each rvalid/rdata lands at the correct master one cycle later.
- Master 0 reads while master 1 writes to 0x0300_0000 with strobe 0xF in the same cycle → both granted, no stall, `s_wdata` equals `m1_wdata`.
- Read granted in cycle N, `rst`=1 in cycle N+1 → no rvalid on either master; after reset release, master 0 wins the first RR conflict.
